i2c_byte_receiver: RTL and testbench



---
 rtl/i2c_byte_receiver.sv | 146 ++++++++++++++
 tb/tb_i2c_byte_receiver.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_receiver.sv
// I2C write-only target: matches ADDRESS, shifts bytes MSB-first, ACKs, hands bytes out over valid/ready.
// A byte completing while the previous one is still unaccepted is NACKed and dropped (sticky overrun).
module i2c_byte_receiver #(
   parameter logic [6:0] ADDRESS    = 7'h2A,
   parameter int         DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_sck_sync,
   input  logic                  i_sda_sync,
   input  logic                  i_start_pulse,
   input  logic                  i_stop_pulse,
   output logic                  o_sda_drive_low,
   output logic                  o_addr_match,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_data_valid,
   input  logic                  i_data_ready,
   output logic                  o_msg_done,
   output logic                  o_overrun
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE} state_t;

   localparam logic [3:0] LAST = 4'(DATA_WIDTH);

   state_t                r_state, w_state;
   logic [3:0]            r_bit_cnt, w_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift, w_shift;
   logic [DATA_WIDTH-1:0] r_data_out, w_data_out;
   logic                  r_sck_q;
   logic                  r_drive, w_drive;
   logic                  r_addr_match, w_addr_match;
   logic                  r_data_valid, w_data_valid;
   logic                  r_msg_done, w_msg_done;
   logic                  r_overrun, w_overrun;
   logic                  r_byte_ok, w_byte_ok;

   logic                  w_sck_rise, w_sck_fall, w_slot_free, w_ack_ok;
   logic [DATA_WIDTH-1:0] w_shift_in;

   assign w_sck_rise  = i_sck_sync & ~r_sck_q;
   assign w_sck_fall  = ~i_sck_sync & r_sck_q;
   assign w_shift_in  = {r_shift[DATA_WIDTH-2:0], i_sda_sync};
   assign w_slot_free = ~r_data_valid | i_data_ready;
   // Address phase ACKs only a write to our address; data phase ACKs only if the byte was stored.
   assign w_ack_ok    = (r_state == S_ADDR) ? ((r_shift[DATA_WIDTH-1:1] == ADDRESS) && !r_shift[0])
                                            : r_byte_ok;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_data_out   <= '0;
         r_sck_q      <= 1'b0;
         r_drive      <= 1'b0;
         r_addr_match <= 1'b0;
         r_data_valid <= 1'b0;
         r_msg_done   <= 1'b0;
         r_overrun    <= 1'b0;
         r_byte_ok    <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_bit_cnt    <= w_bit_cnt;
         r_shift      <= w_shift;
         r_data_out   <= w_data_out;
         r_sck_q      <= i_sck_sync;
         r_drive      <= w_drive;
         r_addr_match <= w_addr_match;
         r_data_valid <= w_data_valid;
         r_msg_done   <= w_msg_done;
         r_overrun    <= w_overrun;
         r_byte_ok    <= w_byte_ok;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_bit_cnt    = r_bit_cnt;
      w_shift      = r_shift;
      w_data_out   = r_data_out;
      w_drive      = r_drive;
      w_addr_match = r_addr_match;
      w_data_valid = r_data_valid & ~i_data_ready;
      w_msg_done   = 1'b0;
      w_overrun    = r_overrun;
      w_byte_ok    = r_byte_ok;

      if (i_stop_pulse) begin
         w_state      = S_IDLE;
         w_drive      = 1'b0;
         w_addr_match = 1'b0;
         w_msg_done   = r_addr_match;
      end else if (i_start_pulse) begin
         w_state      = S_ADDR;
         w_bit_cnt    = '0;
         w_drive      = 1'b0;
         w_addr_match = 1'b0;
      end else begin
         case (r_state)
            S_ADDR, S_DATA: begin
               if (w_sck_rise && (r_bit_cnt < LAST)) begin
                  w_shift   = w_shift_in;
                  w_bit_cnt = r_bit_cnt + 4'd1;
                  if ((r_state == S_DATA) && (r_bit_cnt == LAST - 4'd1)) begin
                     if (w_slot_free) begin
                        w_data_out   = w_shift_in;
                        w_data_valid = 1'b1;
                        w_byte_ok    = 1'b1;
                     end else begin
                        w_overrun    = 1'b1;
                        w_byte_ok    = 1'b0;
                     end
                  end
               end else if (w_sck_fall && (r_bit_cnt == LAST)) begin
                  if (w_ack_ok) begin
                     w_state = (r_state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                     w_drive = 1'b1;
                     if (r_state == S_ADDR) w_addr_match = 1'b1;
                  end else begin
                     w_state = S_IGNORE;
                  end
               end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
               if (w_sck_fall) begin
                  w_drive   = 1'b0;
                  w_bit_cnt = '0;
                  w_state   = S_DATA;
               end
            end
            default: begin
               w_drive = 1'b0;
            end
         endcase
      end
   end

   assign o_sda_drive_low = r_drive;
   assign o_addr_match    = r_addr_match;
   assign o_data_out      = r_data_out;
   assign o_data_valid    = r_data_valid;
   assign o_msg_done      = r_msg_done;
   assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_i2c_byte_receiver.sv
// Bench for i2c_byte_receiver: bit-level I2C master, negedge monitor, per-transaction expectations.
module tb_i2c_byte_receiver;

   logic       i_clk = 1'b0;
   logic       i_reset, i_sck_sync, i_sda_sync, i_start_pulse, i_stop_pulse, i_data_ready;
   logic       o_sda_drive_low, o_addr_match, o_data_valid, o_msg_done, o_overrun;
   logic [7:0] o_data_out;

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0] got_q[$];
   int         done_cnt  = 0;
   int         drive_cnt = 0;
   int         stab_err  = 0;
   logic       prev_valid = 1'b0;
   logic       prev_acc   = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   bit         rnd_ready  = 1'b0;
   logic       post_drive, post_valid;

   always #5 i_clk = ~i_clk;

   i2c_byte_receiver #(.ADDRESS(7'h2A), .DATA_WIDTH(8)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_sck_sync(i_sck_sync), .i_sda_sync(i_sda_sync),
      .i_start_pulse(i_start_pulse), .i_stop_pulse(i_stop_pulse),
      .o_sda_drive_low(o_sda_drive_low), .o_addr_match(o_addr_match),
      .o_data_out(o_data_out), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
      .o_msg_done(o_msg_done), .o_overrun(o_overrun));

   // Accepted bytes, msg_done cycles, drive-low cycles and data_out stability while held.
   always @(negedge i_clk) begin
      if (i_reset) begin
         prev_valid <= 1'b0;
      end else begin
         if (o_data_valid && i_data_ready) got_q.push_back(o_data_out);
         if (o_msg_done) done_cnt <= done_cnt + 1;
         if (o_sda_drive_low) drive_cnt <= drive_cnt + 1;
         if (prev_valid && !prev_acc && o_data_valid && (o_data_out !== prev_data))
            stab_err <= stab_err + 1;
         prev_valid <= o_data_valid;
         prev_acc   <= i_data_ready;
         prev_data  <= o_data_out;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
         if (rnd_ready) i_data_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send_start();
      i_sda_sync = 1'b1; i_sck_sync = 1'b1; tick(3);
      i_start_pulse = 1'b1; tick(1);
      i_start_pulse = 1'b0; i_sda_sync = 1'b0; tick(2);
      i_sck_sync = 1'b0; tick(2);
   endtask

   task automatic send_stop();
      i_sda_sync = 1'b0; tick(2);
      i_sck_sync = 1'b1; tick(3);
      i_stop_pulse = 1'b1; tick(1);
      i_stop_pulse = 1'b0; i_sda_sync = 1'b1; tick(8);
   endtask

   // ack = drive seen in the 9th high phase; spur = drive seen in any data-bit high phase.
   task automatic send_byte(input logic [7:0] b, input bit rst_in_ack, output bit ack, output bit spur);
      spur = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         i_sda_sync = b[i]; tick(3);
         i_sck_sync = 1'b1; tick(2);
         if (o_sda_drive_low) spur = 1'b1;
         tick(2);
         i_sck_sync = 1'b0; tick(1);
      end
      i_sda_sync = 1'b1; tick(3);
      i_sck_sync = 1'b1; tick(2);
      ack = o_sda_drive_low;
      if (rst_in_ack) begin
         i_reset = 1'b1; tick(1);
         i_reset = 1'b0;
         post_drive = o_sda_drive_low;
         post_valid = o_data_valid;
      end
      tick(2);
      i_sck_sync = 1'b0; tick(1);
   endtask

   task automatic test_reset();
      i_reset = 1'b1; tick(3);
      n_total++; if (o_sda_drive_low !== 1'b0) $display("FAIL reset_drive: got %b want 0", o_sda_drive_low); else n_pass++;
      n_total++; if (o_addr_match !== 1'b0) $display("FAIL reset_match: got %b want 0", o_addr_match); else n_pass++;
      n_total++; if (o_data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", o_data_out); else n_pass++;
      n_total++; if (o_data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_data_valid); else n_pass++;
      n_total++; if (o_msg_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_msg_done); else n_pass++;
      n_total++; if (o_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", o_overrun); else n_pass++;
      i_reset = 1'b0; tick(2);
   endtask

   task automatic test_basic();
      int b0, d0;
      bit a0, a1, s0, s1;
      i_data_ready = 1'b1;
      b0 = got_q.size(); d0 = done_cnt;
      send_start();
      send_byte(8'h54, 1'b0, a0, s0);
      send_byte(8'hA5, 1'b0, a1, s1);
      n_total++; if (a0 !== 1'b1) $display("FAIL basic_addr_ack: got %b want 1", a0); else n_pass++;
      n_total++; if (a1 !== 1'b1) $display("FAIL basic_data_ack: got %b want 1", a1); else n_pass++;
      n_total++; if ((s0 | s1) !== 1'b0) $display("FAIL basic_spurious_drive: got %b want 0", s0 | s1); else n_pass++;
      n_total++; if (o_addr_match !== 1'b1) $display("FAIL basic_match_before_stop: got %b want 1", o_addr_match); else n_pass++;
      send_stop();
      n_total++; if (got_q.size() - b0 !== 1) $display("FAIL basic_count: got %0d want 1", got_q.size() - b0); else n_pass++;
      if (got_q.size() > b0) begin
         n_total++; if (got_q[b0] !== 8'hA5) $display("FAIL basic_byte: got %h want a5", got_q[b0]); else n_pass++;
      end
      n_total++; if (done_cnt - d0 !== 1) $display("FAIL basic_msg_done: got %0d want 1", done_cnt - d0); else n_pass++;
      n_total++; if (o_addr_match !== 1'b0) $display("FAIL basic_match_after_stop: got %b want 0", o_addr_match); else n_pass++;
   endtask

   task automatic test_nack_addr(input logic [7:0] addr, input string nm);
      int b0, d0, dr0;
      bit a0, a1, s0, s1;
      i_data_ready = 1'b1;
      b0 = got_q.size(); d0 = done_cnt; dr0 = drive_cnt;
      send_start();
      send_byte(addr, 1'b0, a0, s0);
      send_byte(8'h3C, 1'b0, a1, s1);
      n_total++; if ({a0, a1} !== 2'b00) $display("FAIL %s_acks: got %b want 00", nm, {a0, a1}); else n_pass++;
      n_total++; if (o_addr_match !== 1'b0) $display("FAIL %s_match: got %b want 0", nm, o_addr_match); else n_pass++;
      send_stop();
      n_total++; if (drive_cnt - dr0 !== 0) $display("FAIL %s_drive_cycles: got %0d want 0", nm, drive_cnt - dr0); else n_pass++;
      n_total++; if (got_q.size() - b0 !== 0) $display("FAIL %s_bytes: got %0d want 0", nm, got_q.size() - b0); else n_pass++;
      n_total++; if (done_cnt - d0 !== 0) $display("FAIL %s_msg_done: got %0d want 0", nm, done_cnt - d0); else n_pass++;
   endtask

   task automatic test_overrun();
      int b0, se0;
      bit a0, a1, a2, a3, s;
      i_data_ready = 1'b0;
      b0 = got_q.size(); se0 = stab_err;
      send_start();
      send_byte(8'h54, 1'b0, a0, s);
      send_byte(8'h11, 1'b0, a1, s);
      send_byte(8'h22, 1'b0, a2, s);
      send_byte(8'h33, 1'b0, a3, s);
      n_total++; if ({a0, a1, a2, a3} !== 4'b1100) $display("FAIL ovr_acks: got %b want 1100", {a0, a1, a2, a3}); else n_pass++;
      n_total++; if (o_overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", o_overrun); else n_pass++;
      n_total++; if (o_data_valid !== 1'b1) $display("FAIL ovr_held_valid: got %b want 1", o_data_valid); else n_pass++;
      n_total++; if (o_data_out !== 8'h11) $display("FAIL ovr_held_data: got %h want 11", o_data_out); else n_pass++;
      send_stop();
      i_data_ready = 1'b1; tick(6);
      n_total++; if (got_q.size() - b0 !== 1) $display("FAIL ovr_count: got %0d want 1", got_q.size() - b0); else n_pass++;
      if (got_q.size() > b0) begin
         n_total++; if (got_q[b0] !== 8'h11) $display("FAIL ovr_byte: got %h want 11", got_q[b0]); else n_pass++;
      end
      n_total++; if (o_data_valid !== 1'b0) $display("FAIL ovr_valid_cleared: got %b want 0", o_data_valid); else n_pass++;
      n_total++; if (o_overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", o_overrun); else n_pass++;
      n_total++; if (stab_err - se0 !== 0) $display("FAIL ovr_data_stable: got %0d changes want 0", stab_err - se0); else n_pass++;
   endtask

   task automatic test_repeated_start();
      int b0, d0;
      bit a0, a1, a2, a3, s;
      i_data_ready = 1'b1;
      b0 = got_q.size(); d0 = done_cnt;
      send_start();
      send_byte(8'h54, 1'b0, a0, s);
      send_byte(8'h01, 1'b0, a1, s);
      send_start();
      send_byte(8'h54, 1'b0, a2, s);
      send_byte(8'h02, 1'b0, a3, s);
      send_stop();
      n_total++; if ({a0, a1, a2, a3} !== 4'b1111) $display("FAIL rs_acks: got %b want 1111", {a0, a1, a2, a3}); else n_pass++;
      n_total++; if (got_q.size() - b0 !== 2) $display("FAIL rs_count: got %0d want 2", got_q.size() - b0); else n_pass++;
      if (got_q.size() >= b0 + 2) begin
         n_total++; if ({got_q[b0], got_q[b0+1]} !== 16'h0102) $display("FAIL rs_bytes: got %h%h want 0102", got_q[b0], got_q[b0+1]); else n_pass++;
      end
      n_total++; if (done_cnt - d0 !== 1) $display("FAIL rs_msg_done: got %0d want 1", done_cnt - d0); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int b0, d0;
      bit a0, a1, a2, a3, s;
      i_data_ready = 1'b0;
      send_start();
      send_byte(8'h54, 1'b0, a0, s);
      send_byte(8'h9C, 1'b1, a1, s);
      n_total++; if (a1 !== 1'b1) $display("FAIL rm_ack_before_reset: got %b want 1", a1); else n_pass++;
      n_total++; if (post_drive !== 1'b0) $display("FAIL rm_drive_after_reset: got %b want 0", post_drive); else n_pass++;
      n_total++; if (post_valid !== 1'b0) $display("FAIL rm_valid_after_reset: got %b want 0", post_valid); else n_pass++;
      n_total++; if (o_overrun !== 1'b0) $display("FAIL rm_overrun_cleared: got %b want 0", o_overrun); else n_pass++;
      i_data_ready = 1'b1;
      b0 = got_q.size(); d0 = done_cnt;
      send_start();
      send_byte(8'h54, 1'b0, a2, s);
      send_byte(8'h7E, 1'b0, a3, s);
      send_stop();
      n_total++; if ({a2, a3} !== 2'b11) $display("FAIL rm_after_acks: got %b want 11", {a2, a3}); else n_pass++;
      n_total++; if (got_q.size() - b0 !== 1) $display("FAIL rm_after_count: got %0d want 1", got_q.size() - b0); else n_pass++;
      if (got_q.size() > b0) begin
         n_total++; if (got_q[b0] !== 8'h7E) $display("FAIL rm_after_byte: got %h want 7e", got_q[b0]); else n_pass++;
      end
      n_total++; if (done_cnt - d0 !== 1) $display("FAIL rm_after_msg_done: got %0d want 1", done_cnt - d0); else n_pass++;
   endtask

   // Random write transactions with randomly toggling data_ready; expectations follow the
   // protocol rules directly: only a write to 0x2A is ACKed, its bytes are delivered in order.
   task automatic test_random();
      logic [7:0] exp_q[$];
      int         b0, d0, se0, nseg, nbyte, exp_done;
      logic [7:0] addr, dat;
      bit         ack, s, ok;
      rnd_ready = 1'b1;
      se0 = stab_err;
      for (int t = 0; t < 20; t++) begin
         exp_q.delete();
         b0 = got_q.size(); d0 = done_cnt; exp_done = 0;
         nseg = $urandom_range(1, 2);
         for (int g = 0; g < nseg; g++) begin
            addr = ($urandom_range(0, 1) == 1) ? 8'h54 : 8'($urandom);
            ok = (addr == 8'h54);
            exp_done = ok ? 1 : 0;
            send_start();
            send_byte(addr, 1'b0, ack, s);
            n_total++; if (ack !== ok) $display("FAIL rnd_addr_ack t=%0d addr=%h: got %b want %b", t, addr, ack, ok); else n_pass++;
            nbyte = $urandom_range(1, 3);
            for (int k = 0; k < nbyte; k++) begin
               dat = 8'($urandom);
               send_byte(dat, 1'b0, ack, s);
               n_total++; if ({ack, s} !== {ok, 1'b0}) $display("FAIL rnd_data_ack t=%0d: got ack=%b spur=%b want ack=%b spur=0", t, ack, s, ok); else n_pass++;
               if (ok) exp_q.push_back(dat);
            end
         end
         send_stop();
         tick(8);
         n_total++; if (got_q.size() - b0 !== exp_q.size()) $display("FAIL rnd_count t=%0d: got %0d want %0d", t, got_q.size() - b0, exp_q.size()); else n_pass++;
         for (int k = 0; k < exp_q.size(); k++) begin
            if (b0 + k < got_q.size()) begin
               n_total++; if (got_q[b0+k] !== exp_q[k]) $display("FAIL rnd_byte t=%0d k=%0d: got %h want %h", t, k, got_q[b0+k], exp_q[k]); else n_pass++;
            end
         end
         n_total++; if (done_cnt - d0 !== exp_done) $display("FAIL rnd_msg_done t=%0d: got %0d want %0d", t, done_cnt - d0, exp_done); else n_pass++;
      end
      rnd_ready = 1'b0;
      i_data_ready = 1'b1;
      tick(4);
      n_total++; if (o_overrun !== 1'b0) $display("FAIL rnd_overrun: got %b want 0", o_overrun); else n_pass++;
      n_total++; if (stab_err - se0 !== 0) $display("FAIL rnd_data_stable: got %0d changes want 0", stab_err - se0); else n_pass++;
   endtask

   initial begin
      i_reset = 1'b1; i_sck_sync = 1'b1; i_sda_sync = 1'b1;
      i_start_pulse = 1'b0; i_stop_pulse = 1'b0; i_data_ready = 1'b0;
      test_reset();
      test_basic();
      test_nack_addr(8'h56, "bad_addr");
      test_nack_addr(8'h55, "read_req");
      test_overrun();
      test_repeated_start();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
